uart_rx_os: RTL and testbench

- 16x-oversampling UART receiver for the far end of the link driven by the team's UART transmitter.
- Frame format: 8N1, LSB first. Optional even-parity bit.
- Synchronises the asynchronous serial line, validates the start bit, majority-votes each bit and reports framing/parity errors.
- Sits beside uart_top as a standalone, more noise-robust receive path.

---
 rtl/uart_rx_os.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_os.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x-oversampling UART receiver, 8N1 with majority-voted bits
// Optional even-parity bit enabled by defining UART_PARITY_EN.
module uart_rx_os #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int OS       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] doutrx,
  output logic       donerx,
  output logic       ferr,
  output logic       perr,
  output logic       busy
);

  localparam int DIV_RAW  = CLK_FREQ / (BAUD * OS);
  localparam int TICK_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t        state;
  logic          rx_meta, rxs;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    s;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          v7, v8;
  logic          tick, vote, mid, last;

  assign tick = (state != IDLE) && (state != WAIT_HIGH) && (tick_cnt == TW'(TICK_DIV - 1));
  assign vote = (v7 & v8) | (v7 & rxs) | (v8 & rxs);
  assign mid  = tick && (s == 4'd9);
  assign last = tick && (s == 4'd15);

`ifdef UART_PARITY_EN
  logic par_acc, perr_r;
  assign perr = perr_r;
`else
  assign perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      state    <= IDLE;
      tick_cnt <= '0;
      s        <= 4'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      v7       <= 1'b1;
      v8       <= 1'b1;
      doutrx   <= 8'h00;
      donerx   <= 1'b0;
      ferr     <= 1'b0;
      busy     <= 1'b0;
`ifdef UART_PARITY_EN
      par_acc  <= 1'b0;
      perr_r   <= 1'b0;
`endif
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      donerx  <= 1'b0;
      ferr    <= 1'b0;
`ifdef UART_PARITY_EN
      perr_r  <= 1'b0;
`endif
      if (state == IDLE || state == WAIT_HIGH || tick) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + 1'b1;

      if (tick) begin
        s <= s + 4'd1;
        if (s == 4'd7) v7 <= rxs;
        if (s == 4'd8) v8 <= rxs;
      end

      case (state)
        IDLE: begin
          s <= 4'd0;
          if (!rxs) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (mid && vote) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last) begin
            state   <= DATA;
            bit_idx <= 3'd0;
`ifdef UART_PARITY_EN
            par_acc <= 1'b0;
`endif
          end
        end
        DATA: begin
          if (mid) begin
            shreg <= {vote, shreg[7:1]};
`ifdef UART_PARITY_EN
            par_acc <= par_acc ^ vote;
`endif
          end
          if (last) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (mid) par_acc <= par_acc ^ vote;
          if (last) state <= STOP;
        end
`endif
        STOP: begin
          // Decide mid-stop-bit so a start bit right behind it is still caught
          if (mid) begin
            if (vote) begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef UART_PARITY_EN
              if (par_acc) perr_r <= 1'b1;
              else begin
                doutrx <= shreg;
                donerx <= 1'b1;
              end
`else
              doutrx <= shreg;
              donerx <= 1'b1;
`endif
            end else begin
              state <= WAIT_HIGH;
              ferr  <= 1'b1;
`ifdef UART_PARITY_EN
              perr_r <= par_acc;
`endif
            end
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - randomized self-checking bench for uart_rx_os
// Frame timing and outcomes come from an event-level model; UART_PARITY_EN selects parity frames.
module tb_uart_rx_os;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int TD       = CLK_FREQ / (BAUD * 16);
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // rx fall -> pulse: sync, full bits before stop, mid-stop decision, output register
  localparam int LAT = 2 + TD * (16 * (NB - 1) + 10) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] doutrx;
  logic       donerx, ferr, perr, busy;

  uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OS(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .doutrx(doutrx),
    .donerx(donerx), .ferr(ferr), .perr(perr), .busy(busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] kind;   // {perr, ferr, donerx}
    logic [7:0] data;
    longint     at;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_dout = 8'h00;
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input longint act, input longint want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  ev_t ev;
  longint dt;
  always @(negedge clk) begin
    if (!rst) begin
      model_dout = 8'h00;
    end else begin
      if (exp_q.size() > 0 && cyc > exp_q[0].at + TD) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missing_pulse: got none expected kind %0b at cycle %0d", exp_q[0].kind, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (donerx || ferr || perr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {perr, ferr, donerx}, 3'b000);
        end else begin
          ev = exp_q.pop_front();
          chk("pulse_kind", {perr, ferr, donerx}, ev.kind);
          dt = cyc - ev.at;
          chk("pulse_time_in_tol", (dt >= -TD && dt <= TD), 1);
          if (ev.kind == 3'b001) model_dout = ev.data;
        end
      end
      chk("doutrx_hold", doutrx, model_dout);
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bad,
                            input int glitch_at, input int extra_low, output logic busy_mid);
    logic lv[$];
    ev_t  e;
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
`ifdef UART_PARITY_EN
    lv.push_back((^b) ^ par_bad);
`endif
    lv.push_back(stop_bit);
    e.data = b;
    e.at   = cyc + LAT;
    if (!stop_bit) e.kind = par_bad ? 3'b110 : 3'b010;
    else           e.kind = par_bad ? 3'b100 : 3'b001;
    exp_q.push_back(e);
    busy_mid = 1'b0;
    for (int k = 0; k < NB * 16 * TD; k++) begin
      rx = lv[k / (16 * TD)];
      if (k == glitch_at) rx = ~rx;
      @(posedge clk);
      #1;
      if (k == NB * 8 * TD) busy_mid = busy;
    end
    rx = 1'b0;
    repeat (extra_low) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic       bm;
  logic [7:0] rb;
  int         r, gap, tmo;

  initial begin
    rx  = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_doutrx", doutrx, 8'h00);
    chk("rst_donerx", donerx, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_perr", perr, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    idle(10);

    send_frame(8'h5A, 1'b1, 1'b0, -1, 0, bm);
    chk("busy_mid_5a", bm, 1);
    chk("dout_5a", doutrx, 8'h5A);
    chk("busy_after_5a", busy, 0);
    idle(5);

    send_frame(8'hA5, 1'b1, 1'b0, -1, 0, bm);
    chk("dout_a5", doutrx, 8'hA5);
    send_frame(8'h3C, 1'b1, 1'b0, -1, 0, bm);
    chk("dout_3c", doutrx, 8'h3C);
    idle(8);

    rx = 1'b0;
    repeat (4 * TD) begin
      @(posedge clk);
      #1;
    end
    idle(30);
    chk("glitch_busy", busy, 0);
    chk("glitch_dout", doutrx, 8'h3C);

    send_frame(8'hFF, 1'b0, 1'b0, -1, 40, bm);
    chk("ferr_wait_busy", busy, 1);
    chk("ferr_dout_kept", doutrx, 8'h3C);
    idle(5);
    chk("ferr_busy_after_rise", busy, 0);
    send_frame(8'h11, 1'b1, 1'b0, -1, 0, bm);
    chk("dout_11", doutrx, 8'h11);
    idle(5);

    send_frame(8'h5A, 1'b1, 1'b0, (16 * 4 + 8) * TD, 0, bm);
    chk("vote_dout_5a", doutrx, 8'h5A);
    idle(5);

    rx = 1'b0;
    repeat (16 * TD) begin @(posedge clk); #1; end
    for (int i = 0; i < 4; i++) begin
      rb = 8'h81;
      rx = rb[i];
      repeat (16 * TD) begin @(posedge clk); #1; end
    end
    rx = 1'b0;
    repeat (8 * TD) begin @(posedge clk); #1; end
    rst = 1'b0;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_doutrx", doutrx, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_pulses", {perr, ferr, donerx}, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, 1'b0, -1, 0, bm);
    chk("dout_81", doutrx, 8'h81);
    idle(5);

`ifdef UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1, 0, bm);
    chk("par_good_dout", doutrx, 8'h07);
    idle(5);
    send_frame(8'h07, 1'b1, 1'b1, -1, 0, bm);
    chk("par_bad_dout_kept", doutrx, 8'h07);
    idle(5);
`endif

    for (int f = 0; f < 16; f++) begin
      rb  = 8'($urandom);
      r   = $urandom_range(0, 5);
      gap = $urandom_range(0, 20);
      if (r == 0) begin
        send_frame(rb, 1'b0, 1'b0, -1, $urandom_range(16, 40), bm);
        gap = gap + 4;
      end else if (r == 1) begin
        send_frame(rb, 1'b1, 1'b0, (16 * (1 + $urandom_range(0, 7)) + 8) * TD, 0, bm);
`ifdef UART_PARITY_EN
      end else if (r == 2) begin
        send_frame(rb, 1'b1, 1'b1, -1, 0, bm);
`endif
      end else begin
        send_frame(rb, 1'b1, 1'b0, -1, 0, bm);
      end
      idle(gap);
    end

    tmo = 0;
    while (exp_q.size() > 0 && tmo < 400) begin
      idle(1);
      tmo++;
    end
    chk("events_drained", exp_q.size(), 0);
    chk("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
